// File: rtl/accel_regif.sv
// Register front end for a single-shot accelerator: argument, control, status and result
// registers, plus an idle/run sequencer guarded by a watchdog.
module accel_regif #(
   parameter int unsigned DW   = 32,
   parameter int unsigned NARG = 2,
   parameter int unsigned TMO  = 1024,
   localparam int unsigned AW  = $clog2(NARG + 3)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [AW-1:0]      a,
   input  logic               we,
   input  logic               re,
   input  logic [DW-1:0]      wd,
   output logic [DW-1:0]      rd,
   output logic               rvalid,
   output logic [NARG*DW-1:0] arg,
   output logic               start,
   input  logic               acc_done,
   input  logic [DW-1:0]      acc_result,
   output logic               irq
);

   localparam int unsigned CW = (TMO > 1) ? $clog2(TMO) : 1;
   localparam logic [CW-1:0] CntLast = (TMO > 0) ? CW'(TMO - 1) : '0;
   localparam logic [AW-1:0] ACtrl   = AW'(NARG);
   localparam logic [AW-1:0] AStatus = AW'(NARG + 1);
   localparam logic [AW-1:0] AResult = AW'(NARG + 2);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] arg_q [NARG];
   logic [DW-1:0] result_q, rd_q, rdata;
   logic [CW-1:0] cnt_q;
   logic          irq_en_q, done_q, err_q, tmo_q, start_q, rvalid_q;
   logic          busy, arg_wr, ctrl_wr, go, clr, launch, reject, clr_apply;
   logic          fin_done, fin_tmo;

   always_comb begin
      arg_wr    = we && (a < ACtrl);
      ctrl_wr   = we && (a == ACtrl);
      go        = ctrl_wr && wd[0];
      clr       = ctrl_wr && wd[1];
      launch    = (state_q == StIdle) && go;
      reject    = (state_q == StRun) && (go || arg_wr);
      // A rejected go/clr write only flags err; its clr part is dropped with it.
      clr_apply = clr && !reject;
      fin_done  = (state_q == StRun) && acc_done;
      fin_tmo   = (state_q == StRun) && (TMO > 0) && (cnt_q == CntLast) && !acc_done;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (launch) state_d = StRun;
         StRun:  if (fin_done || fin_tmo) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy = (state_q == StRun);
      irq  = irq_en_q & (done_q | tmo_q);
   end

   always_comb begin
      rdata = '0;
      for (int k = 0; k < NARG; k++) begin
         if (a == AW'(k)) rdata = arg_q[k];
      end
      if (a == ACtrl)   rdata[2]   = irq_en_q;
      if (a == AStatus) rdata[3:0] = {tmo_q, err_q, done_q, busy};
      if (a == AResult) rdata      = result_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NARG; k++) arg_q[k] <= '0;
         result_q <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         tmo_q    <= 1'b0;
         start_q  <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         start_q  <= launch;
         rvalid_q <= re;
         if (re) rd_q <= rdata;

         if (launch) begin
            cnt_q <= '0;
         end else if (busy) begin
            cnt_q <= cnt_q + CW'(1);
         end

         if (ctrl_wr) irq_en_q <= wd[2];

         if (!busy && arg_wr) begin
            for (int k = 0; k < NARG; k++) begin
               if (a == AW'(k)) arg_q[k] <= wd;
            end
         end

         if (fin_done) result_q <= acc_result;

         // Set events take priority over clears landing on the same edge.
         if (fin_done) begin
            done_q <= 1'b1;
         end else if (launch || clr_apply) begin
            done_q <= 1'b0;
         end

         if (fin_tmo) begin
            tmo_q <= 1'b1;
         end else if (launch || clr_apply) begin
            tmo_q <= 1'b0;
         end

         if (reject) begin
            err_q <= 1'b1;
         end else if (clr_apply) begin
            err_q <= 1'b0;
         end
      end
   end

   for (genvar g = 0; g < NARG; g++) begin : g_arg
      assign arg[g*DW +: DW] = arg_q[g];
   end

   assign rd     = rd_q;
   assign rvalid = rvalid_q;
   assign start  = start_q;

endmodule

// File: tb/tb_accel_regif.sv
// Scoreboard bench for accel_regif: directed scenarios followed by random register traffic
// checked against a transaction-level model of the register block.
module tb_accel_regif;

   localparam int DW   = 32;
   localparam int NARG = 2;
   localparam int TMO  = 16;
   localparam int AW   = $clog2(NARG + 3);
   localparam int CWID = NARG * DW;
   localparam int ACTRL = NARG;
   localparam int ASTAT = NARG + 1;
   localparam int ARES  = NARG + 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [AW-1:0]   a = '0;
   logic            we = 1'b0;
   logic            re = 1'b0;
   logic [DW-1:0]   wd = '0;
   logic [DW-1:0]   rd;
   logic            rvalid;
   logic [CWID-1:0] arg;
   logic            start;
   logic            acc_done = 1'b0;
   logic [DW-1:0]   acc_result = '0;
   logic            irq;

   accel_regif #(.DW(DW), .NARG(NARG), .TMO(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .we(we), .re(re), .wd(wd), .rd(rd), .rvalid(rvalid),
      .arg(arg), .start(start), .acc_done(acc_done), .acc_result(acc_result), .irq(irq)
   );

   always #5 clk = ~clk;

   // Reference model: register contents plus how many run cycles have elapsed.
   logic [DW-1:0] m_arg [NARG];
   logic [DW-1:0] m_result;
   bit            m_irq_en, m_done, m_err, m_tmo, m_busy, m_start;
   int            m_run_cycles;

   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] last_rd = '0;
   int            n_checks = 0;
   int            n_err = 0;

   task automatic check(input string name, input logic [CWID-1:0] act,
                        input logic [CWID-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] model_read(input int addr);
      if (addr < NARG) return m_arg[addr];
      if (addr == ACTRL) return DW'(m_irq_en) << 2;
      if (addr == ASTAT) return DW'({m_tmo, m_err, m_done, m_busy});
      if (addr == ARES) return m_result;
      return '0;
   endfunction

   function automatic logic [CWID-1:0] model_args();
      logic [CWID-1:0] p;
      for (int k = 0; k < NARG; k++) p[k*DW +: DW] = m_arg[k];
      return p;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NARG; k++) m_arg[k] = '0;
      m_result = '0;
      {m_irq_en, m_done, m_err, m_tmo, m_busy, m_start} = '0;
      m_run_cycles = 0;
   endtask

   task automatic model_step(input bit w, input int addr, input logic [DW-1:0] d,
                             input bit dn, input logic [DW-1:0] res);
      bit was_busy = m_busy;
      bit is_ctrl = w && (addr == ACTRL);
      bit is_arg = w && (addr < NARG);
      bit go = is_ctrl && d[0];
      bit clr = is_ctrl && d[1];
      bit set_done = 0, set_tmo = 0, set_err = 0, launch = 0;
      if (was_busy) begin
         m_run_cycles++;
         if (dn) set_done = 1;
         else if (TMO > 0 && m_run_cycles == TMO) set_tmo = 1;
         set_err = go || is_arg;
      end else begin
         launch = go;
      end
      if (clr && !set_err) begin
         m_done = 0; m_err = 0; m_tmo = 0;
      end
      if (launch) begin
         m_done = 0; m_tmo = 0; m_run_cycles = 0; m_busy = 1;
      end
      if (!was_busy && is_arg) m_arg[addr] = d;
      if (is_ctrl) m_irq_en = d[2];
      if (set_done) begin
         m_done = 1; m_result = res; m_busy = 0;
      end
      if (set_tmo) begin
         m_tmo = 1; m_busy = 0;
      end
      if (set_err) m_err = 1;
      m_start = launch;
   endtask

   // One bus cycle; called at posedge+1, returns at the following posedge+1.
   task automatic cycle(input bit w, input bit r, input int addr, input logic [DW-1:0] d,
                        input bit dn = 0, input logic [DW-1:0] res = '0,
                        input bit dir = 0, input logic [DW-1:0] dexp = '0);
      we = w; re = r; a = AW'(addr); wd = d; acc_done = dn; acc_result = res;
      if (r) exp_q.push_back(dir ? dexp : model_read(addr));
      @(posedge clk);
      model_step(w, addr, d, dn, res);
      #1;
      we = 0; re = 0; acc_done = 0;
      check("start", start, m_start);
      check("irq", irq, m_irq_en & (m_done | m_tmo));
      check("arg", arg, model_args());
      check("rvalid", rvalid, r);
   endtask

   task automatic wr(input int addr, input logic [DW-1:0] d);
      cycle(1, 0, addr, d);
   endtask

   task automatic rdx(input int addr, input logic [DW-1:0] exp);
      cycle(0, 1, addr, '0, 0, '0, 1, exp);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, '0);
   endtask

   task automatic done_cyc(input logic [DW-1:0] res);
      cycle(0, 0, 0, '0, 1, res);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd"}, rd, 0);
      check({tag, "_rvalid"}, rvalid, 0);
      check({tag, "_start"}, start, 0);
      check({tag, "_irq"}, irq, 0);
      check({tag, "_arg"}, arg, 0);
   endtask

   task automatic do_reset();
      #1 rst_n = 0;
      #1 check_all_zero("reset_mid");
      exp_q.delete();
      last_rd = '0;
      model_reset();
      @(posedge clk);
      #1 rst_n = 1;
   endtask

   // Read monitor: pops an expectation whenever rd is presented, else rd must hold.
   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (rst_n) begin
         if (rvalid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL rvalid_unexpected: rd=0x%0h with no read outstanding", rd);
            end else begin
               e = exp_q.pop_front();
               n_checks++;
               if (rd !== e) begin
                  n_err++;
                  $display("FAIL read_data: got 0x%0h, expected 0x%0h (t=%0t)", rd, e, $time);
               end
            end
         end else begin
            n_checks++;
            if (rd !== last_rd) begin
               n_err++;
               $display("FAIL rd_hold: got 0x%0h, expected 0x%0h (t=%0t)", rd, last_rd, $time);
            end
         end
         last_rd = rd;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      #2 rst_n = 0;
      #1 check_all_zero("reset_init");
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1;

      // Basic operation with interrupt enabled.
      wr(0, 5);
      wr(1, 7);
      wr(ACTRL, 5);
      rdx(ASTAT, 32'h1);
      idle(2);
      done_cyc(32'h78);
      rdx(ASTAT, 32'h2);
      check("irq_after_done", irq, 1);
      rdx(ARES, 32'h78);
      rdx(0, 5);

      // Read and write of the same register in one cycle returns the old value.
      cycle(1, 1, 1, 32'h11, 0, '0, 1, 32'h7);
      rdx(1, 32'h11);

      // Watchdog expiry after exactly TMO run cycles, then clear.
      wr(ACTRL, 5);
      idle(TMO - 1);
      rdx(ASTAT, 32'h1);
      rdx(ASTAT, 32'h8);
      check("irq_after_tmo", irq, 1);
      wr(ACTRL, 2);
      rdx(ASTAT, 32'h0);
      check("irq_after_clr", irq, 0);

      // Rejected writes while busy.
      wr(ACTRL, 1);
      wr(0, 9);
      wr(ACTRL, 1);
      rdx(ASTAT, 32'h5);
      rdx(0, 5);
      done_cyc(32'h33);
      rdx(ASTAT, 32'h6);

      // Completion on the last watchdog cycle wins; set wins over a coincident clr.
      wr(ACTRL, 3);
      idle(TMO - 1);
      done_cyc(32'hABC);
      rdx(ASTAT, 32'h2);
      rdx(ARES, 32'hABC);
      wr(ACTRL, 1);
      cycle(1, 0, ACTRL, 32'h2, 1, 32'h55);
      rdx(ASTAT, 32'h2);
      rdx(ARES, 32'h55);

      // Reset mid-run aborts; later completion is ignored.
      wr(ACTRL, 5);
      idle(2);
      do_reset();
      rdx(5, 32'h0);
      done_cyc(32'h99);
      rdx(ASTAT, 32'h0);
      rdx(ARES, 32'h0);
      idle(2);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         bit w = ($urandom_range(0, 2) == 0);
         bit r = ($urandom_range(0, 2) == 0);
         int addr = int'($urandom_range(0, (1 << AW) - 1));
         bit dn = ($urandom_range(0, 9) == 0);
         cycle(w, r, addr, DW'($urandom), dn, DW'($urandom));
      end

      idle(2);
      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
